// File: rtl/spatz_valu_sequencer_pkg.sv
// Shared types and constants for the vector integer ALU sequencer.
//   valu_op_e    : arithmetic/logic operation encoding (values above VXOR are illegal)
//   vew_e        : selected element width (SEW)
//   seq_state_e  : sequencer FSM states
//   WordWidth / NrWordsPerVreg / VrfAddrWidth / vrf_addr_t : default VRF geometry
package spatz_valu_sequencer_pkg;

    localparam int unsigned VLEN           = 256;
    localparam int unsigned WordWidth      = 64;
    localparam int unsigned NrVregs        = 32;
    localparam int unsigned NrWordsPerVreg = VLEN / WordWidth;
    localparam int unsigned VrfAddrWidth   = $clog2(NrVregs * NrWordsPerVreg);

    typedef logic [VrfAddrWidth-1:0] vrf_addr_t;

    typedef enum logic [1:0] {
        EW_8  = 2'd0,
        EW_16 = 2'd1,
        EW_32 = 2'd2,
        EW_64 = 2'd3
    } vew_e;

    typedef enum logic [2:0] {
        VADD = 3'd0,
        VSUB = 3'd1,
        VAND = 3'd2,
        VOR  = 3'd3,
        VXOR = 3'd4
    } valu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/spatz_simd_alu.sv
// Combinational SIMD integer ALU: result = b op a, element-wise at SEW.
//   op     : operation
//   sew    : element width; ADD/SUB carries/borrows stay inside each element
//   a      : operand A (vs1 or replicated scalar)
//   b      : operand B (vs2)
//   result : element-wise result
module spatz_simd_alu
    import spatz_valu_sequencer_pkg::*;
#(
    parameter int unsigned Width = 64
) (
    input  valu_op_e          op,
    input  vew_e              sew,
    input  logic [Width-1:0]  a,
    input  logic [Width-1:0]  b,
    output logic [Width-1:0]  result
);

    logic sub;
    assign sub = (op == VSUB);

    always_comb begin
        result = '0;
        case (op)
            VAND: result = b & a;
            VOR:  result = b | a;
            VXOR: result = b ^ a;
            VADD, VSUB: begin
                // Each lane is computed in its own slice, so carries never
                // propagate across element boundaries.
                case (sew)
                    EW_8:
                        for (int i = 0; i < Width/8; i++)
                            result[i*8 +: 8] = sub ? b[i*8 +: 8] - a[i*8 +: 8]
                                                   : b[i*8 +: 8] + a[i*8 +: 8];
                    EW_16:
                        for (int i = 0; i < Width/16; i++)
                            result[i*16 +: 16] = sub ? b[i*16 +: 16] - a[i*16 +: 16]
                                                     : b[i*16 +: 16] + a[i*16 +: 16];
                    EW_32:
                        for (int i = 0; i < Width/32; i++)
                            result[i*32 +: 32] = sub ? b[i*32 +: 32] - a[i*32 +: 32]
                                                     : b[i*32 +: 32] + a[i*32 +: 32];
                    default:
                        for (int i = 0; i < Width/64; i++)
                            result[i*64 +: 64] = sub ? b[i*64 +: 64] - a[i*64 +: 64]
                                                     : b[i*64 +: 64] + a[i*64 +: 64];
                endcase
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/spatz_valu_sequencer.sv
// Vector integer ALU sequencer. Accepts one decoded request, walks vd word by
// word (read vs1/vs2 -> compute -> write with byte enables), then pulses a
// completion response.
//   req_*      : request handshake and decoded fields from the controller
//   rsp_*      : one-cycle completion pulse with tag and illegal-op flag
//   vrf_r*     : two read ports ([0] = vs1, [1] = vs2), valid may differ per port
//   vrf_w*     : write port, held stable until vrf_wvalid_i
module spatz_valu_sequencer #(
    parameter int unsigned VLEN      = 256,
    parameter int unsigned WordWidth = 64,
    parameter int unsigned NrVregs   = 32,
    parameter int unsigned VlWidth   = 6,
    parameter int unsigned IdWidth   = 3,
    localparam int unsigned AddrW    = $clog2(NrVregs * (VLEN / WordWidth))
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [2:0]                 req_op_i,
    input  logic [4:0]                 req_vd_i,
    input  logic [4:0]                 req_vs1_i,
    input  logic [4:0]                 req_vs2_i,
    input  logic                       req_use_scalar_i,
    input  logic [WordWidth-1:0]       req_rs1_i,
    input  logic [1:0]                 req_vsew_i,
    input  logic [VlWidth-1:0]         req_vl_i,
    input  logic [IdWidth-1:0]         req_id_i,
    output logic                       rsp_valid_o,
    output logic [IdWidth-1:0]         rsp_id_o,
    output logic                       rsp_err_o,
    output logic [1:0][AddrW-1:0]      vrf_raddr_o,
    output logic [1:0]                 vrf_re_o,
    input  logic [1:0][WordWidth-1:0]  vrf_rdata_i,
    input  logic [1:0]                 vrf_rvalid_i,
    output logic [AddrW-1:0]           vrf_waddr_o,
    output logic [WordWidth-1:0]       vrf_wdata_o,
    output logic                       vrf_we_o,
    output logic [WordWidth/8-1:0]     vrf_wbe_o,
    input  logic                       vrf_wvalid_i
);
    import spatz_valu_sequencer_pkg::*;

    localparam int unsigned NrWords  = VLEN / WordWidth;
    localparam int unsigned BytesW   = WordWidth / 8;
    localparam int unsigned ByteOffW = $clog2(BytesW);
    localparam int unsigned IdxW     = (NrWords > 1) ? $clog2(NrWords) : 1;
    localparam int unsigned NbW      = VlWidth + 3;   // vl << 3 never overflows

    seq_state_e               state_q, state_d;
    valu_op_e                 op_q;
    vew_e                     sew_q;
    logic [4:0]               vd_q, vs1_q, vs2_q;
    logic                     scalar_q, err_q;
    logic [WordWidth-1:0]     rs1_q;
    logic [IdWidth-1:0]       id_q;
    logic [IdxW-1:0]          widx_q, last_q;
    logic [ByteOffW-1:0]      rem_q;
    logic                     got1_q, got2_q;
    logic [WordWidth-1:0]     op1_q, op2_q, res_q;

    function automatic logic [AddrW-1:0] word_addr(input logic [4:0] vreg,
                                                   input logic [IdxW-1:0] idx);
        return AddrW'(vreg) * AddrW'(NrWords) + AddrW'(idx);
    endfunction

    // Request sizing: bytes touched (clamped to one register) and word count.
    logic [NbW-1:0] vl_bytes, nbytes, nwords;
    logic           illegal;
    assign vl_bytes = NbW'(req_vl_i) << req_vsew_i;
    assign nbytes   = (vl_bytes > NbW'(VLEN/8)) ? NbW'(VLEN/8) : vl_bytes;
    assign nwords   = (nbytes + NbW'(BytesW-1)) >> ByteOffW;
    assign illegal  = (req_op_i > VXOR);

    // Scalar operand replicated at SEW.
    logic [WordWidth-1:0] rep;
    always_comb begin
        rep = '0;
        case (sew_q)
            EW_8:    for (int i = 0; i < WordWidth/8;  i++) rep[i*8  +: 8]  = rs1_q[7:0];
            EW_16:   for (int i = 0; i < WordWidth/16; i++) rep[i*16 +: 16] = rs1_q[15:0];
            EW_32:   for (int i = 0; i < WordWidth/32; i++) rep[i*32 +: 32] = rs1_q[31:0];
            default: for (int i = 0; i < WordWidth/64; i++) rep[i*64 +: 64] = rs1_q[63:0];
        endcase
    end

    // Operands forward from the read ports in the cycle they arrive, so the
    // result can be registered as soon as the last needed port shows rvalid.
    logic                 rd_done;
    logic [WordWidth-1:0] opa, opb, alu_res;
    assign rd_done = (scalar_q | got1_q | vrf_rvalid_i[0]) & (got2_q | vrf_rvalid_i[1]);
    assign opa     = scalar_q ? rep : (got1_q ? op1_q : vrf_rdata_i[0]);
    assign opb     = got2_q ? op2_q : vrf_rdata_i[1];

    spatz_simd_alu #(.Width(WordWidth)) i_alu (
        .op     (op_q),
        .sew    (sew_q),
        .a      (opa),
        .b      (opb),
        .result (alu_res)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (req_valid_i) state_d = (illegal || nwords == '0) ? DONE : READ;
            READ:  if (rd_done) state_d = WRITE;
            WRITE: if (vrf_wvalid_i) state_d = (widx_q == last_q) ? DONE : READ;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == IDLE);
        rsp_valid_o = (state_q == DONE);
        rsp_id_o    = (state_q == DONE) ? id_q : '0;
        rsp_err_o   = (state_q == DONE) & err_q;
        vrf_re_o    = '0;
        vrf_raddr_o = '0;
        vrf_we_o    = 1'b0;
        vrf_waddr_o = '0;
        vrf_wdata_o = '0;
        vrf_wbe_o   = '0;
        if (state_q == READ) begin
            vrf_re_o       = {1'b1, ~scalar_q};
            vrf_raddr_o[0] = word_addr(vs1_q, widx_q);
            vrf_raddr_o[1] = word_addr(vs2_q, widx_q);
        end
        if (state_q == WRITE) begin
            vrf_we_o    = 1'b1;
            vrf_waddr_o = word_addr(vd_q, widx_q);
            vrf_wdata_o = res_q;
            vrf_wbe_o   = '1;
            // Partial tail: only bytes below nbytes mod BytesW on the last word.
            if (widx_q == last_q && rem_q != '0)
                vrf_wbe_o = (BytesW'(1) << rem_q) - BytesW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            op_q     <= VADD;
            sew_q    <= EW_8;
            vd_q     <= '0;
            vs1_q    <= '0;
            vs2_q    <= '0;
            scalar_q <= 1'b0;
            err_q    <= 1'b0;
            rs1_q    <= '0;
            id_q     <= '0;
            widx_q   <= '0;
            last_q   <= '0;
            rem_q    <= '0;
            got1_q   <= 1'b0;
            got2_q   <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            res_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (req_valid_i) begin
                    op_q     <= valu_op_e'(req_op_i);
                    sew_q    <= vew_e'(req_vsew_i);
                    vd_q     <= req_vd_i;
                    vs1_q    <= req_vs1_i;
                    vs2_q    <= req_vs2_i;
                    scalar_q <= req_use_scalar_i;
                    rs1_q    <= req_rs1_i;
                    id_q     <= req_id_i;
                    err_q    <= illegal;
                    widx_q   <= '0;
                    last_q   <= IdxW'(nwords - NbW'(1));
                    rem_q    <= nbytes[ByteOffW-1:0];
                    got1_q   <= 1'b0;
                    got2_q   <= 1'b0;
                end
                READ: begin
                    if (vrf_re_o[0] && vrf_rvalid_i[0]) begin
                        op1_q  <= vrf_rdata_i[0];
                        got1_q <= 1'b1;
                    end
                    if (vrf_rvalid_i[1]) begin
                        op2_q  <= vrf_rdata_i[1];
                        got2_q <= 1'b1;
                    end
                    if (rd_done) begin
                        res_q  <= alu_res;
                        got1_q <= 1'b0;
                        got2_q <= 1'b0;
                    end
                end
                WRITE: if (vrf_wvalid_i && widx_q != last_q) widx_q <= widx_q + IdxW'(1);
                default: ;
            endcase
        end
    end

endmodule
